vita49_pack_v2: RTL and testbench

- Parametrised next-generation VITA-49 IF-data packetiser.
- Sits between a 32-bit AXI-Stream sample source and the DMA/framer path.
- Wraps payload into packets with a header, stream ID, optional TSI/TSF timestamp and optional trailer.
- Supports a programmable packet count, a short final packet, a sticky status word and a passthrough mode.

---
 rtl/vita49_pack_v2.sv | 182 ++++++++++++++++++
 tb/tb_vita49_pack_v2.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vita49_pack_v2.sv
// VITA-49 IF-data packetiser: wraps a 32-bit AXI-Stream sample stream into
// packets of header, stream ID, optional TSI/TSF timestamp, payload and an
// optional trailer. It also provides a passthrough mode and a sticky status word.
module vita49_pack_v2 #(
  parameter int PKT_SIZE_W = 16,
  parameter int WTP_W      = 32,
  parameter int TS_EN      = 1,
  parameter int TRAILER_EN = 1
) (
  input  logic                  AXIS_ACLK,
  input  logic                  AXIS_ARESET,
  input  logic [31:0]           S_AXIS_TDATA,
  input  logic                  S_AXIS_TVALID,
  output logic                  S_AXIS_TREADY,
  output logic [31:0]           M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY,
  input  logic [31:0]           ctrl,
  output logic [31:0]           status,
  input  logic [31:0]           streamID,
  input  logic [PKT_SIZE_W-1:0] pkt_size,
  input  logic [WTP_W-1:0]      words_to_pack,
  input  logic [31:0]           timestamp_sec,
  input  logic [63:0]           timestamp_fsec
);

  localparam int         OVH     = 2 + ((TS_EN != 0) ? 3 : 0) + ((TRAILER_EN != 0) ? 1 : 0);
  localparam logic       TR_BIT  = (TRAILER_EN != 0);
  localparam logic [1:0] TS_BITS = (TS_EN != 0) ? 2'b01 : 2'b00;

  typedef enum logic [2:0] {
    IDLE, HDR, SID, TSI, TSF_HI, TSF_LO, PAYLOAD, TRAILER
  } state_t;

  state_t                state, next_state, after_pkt;
  logic [31:0]           sid_r, sec_r;
  logic [63:0]           fsec_r;
  logic [PKT_SIZE_W-1:0] psize_r, pay_cnt, plen;
  logic [WTP_W-1:0]      remaining_r, rem_after;
  logic                  cont_r, busy_r, done_r, cfg_err_r;
  logic [3:0]            pkt_cnt;
  logic [15:0]           sent_cnt, hdr_len;
  logic [31:0]           hdr_word;
  logic                  hs, pkt_end, pay_last, final_pkt, start_req, cfg_bad;

  // Payload length of the current packet: a full packet, or whatever is left of a finite run
  always_comb begin
    plen = psize_r;
    if (!cont_r && remaining_r < WTP_W'(psize_r))
      plen = PKT_SIZE_W'(remaining_r);
  end

  assign final_pkt = !cont_r && (remaining_r <= WTP_W'(psize_r));
  assign rem_after = remaining_r - WTP_W'(plen);
  assign pay_last  = (pay_cnt == plen - PKT_SIZE_W'(1));
  assign hdr_len   = 16'(OVH) + 16'(plen);
  assign hdr_word  = {4'b0001, 1'b0, TR_BIT, 2'b00, TS_BITS, TS_BITS, pkt_cnt, hdr_len};
  assign start_req = (state == IDLE) && ctrl[0] && !ctrl[2] && !done_r;
  assign cfg_bad   = (pkt_size == '0) || ((64'(pkt_size) + 64'(OVH)) > 64'd65535);
  assign after_pkt = (!final_pkt && ctrl[0]) ? HDR : IDLE;
  assign hs        = M_AXIS_TVALID && M_AXIS_TREADY;
  assign pkt_end   = hs && M_AXIS_TLAST;
  assign status    = {sent_cnt, 8'h00, pkt_cnt, 1'b0, cfg_err_r, done_r, busy_r};

  // State register; soft reset returns to IDLE even mid-packet
  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET)
      state <= IDLE;
    else if (ctrl[1])
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next-state and output mux; every word advances only on a sink handshake
  always_comb begin
    next_state    = state;
    M_AXIS_TDATA  = '0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TLAST  = 1'b0;
    S_AXIS_TREADY = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl[2]) begin
          M_AXIS_TDATA  = S_AXIS_TDATA;
          M_AXIS_TVALID = S_AXIS_TVALID;
          S_AXIS_TREADY = M_AXIS_TREADY;
        end else if (start_req && !cfg_bad) begin
          next_state = HDR;
        end
      end
      HDR: begin
        M_AXIS_TDATA  = hdr_word;
        M_AXIS_TVALID = 1'b1;
        if (M_AXIS_TREADY) next_state = SID;
      end
      SID: begin
        M_AXIS_TDATA  = sid_r;
        M_AXIS_TVALID = 1'b1;
        if (M_AXIS_TREADY) next_state = (TS_EN != 0) ? TSI : PAYLOAD;
      end
      TSI: begin
        M_AXIS_TDATA  = sec_r;
        M_AXIS_TVALID = 1'b1;
        if (M_AXIS_TREADY) next_state = TSF_HI;
      end
      TSF_HI: begin
        M_AXIS_TDATA  = fsec_r[63:32];
        M_AXIS_TVALID = 1'b1;
        if (M_AXIS_TREADY) next_state = TSF_LO;
      end
      TSF_LO: begin
        M_AXIS_TDATA  = fsec_r[31:0];
        M_AXIS_TVALID = 1'b1;
        if (M_AXIS_TREADY) next_state = PAYLOAD;
      end
      PAYLOAD: begin
        M_AXIS_TDATA  = S_AXIS_TDATA;
        M_AXIS_TVALID = S_AXIS_TVALID;
        S_AXIS_TREADY = M_AXIS_TREADY;
        M_AXIS_TLAST  = !TR_BIT && pay_last;
        if (S_AXIS_TVALID && M_AXIS_TREADY && pay_last)
          next_state = TR_BIT ? TRAILER : after_pkt;
      end
      TRAILER: begin
        M_AXIS_TDATA  = {31'b0, final_pkt};
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TLAST  = 1'b1;
        if (M_AXIS_TREADY) next_state = after_pkt;
      end
      default: next_state = IDLE;
    endcase
  end

  // Run configuration, timestamps, counters and sticky status flags
  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      sid_r <= '0; psize_r <= '0; remaining_r <= '0; cont_r <= 1'b0;
      sec_r <= '0; fsec_r <= '0; pay_cnt <= '0; pkt_cnt <= '0; sent_cnt <= '0;
      busy_r <= 1'b0; done_r <= 1'b0; cfg_err_r <= 1'b0;
    end else if (ctrl[1]) begin
      sid_r <= '0; psize_r <= '0; remaining_r <= '0; cont_r <= 1'b0;
      sec_r <= '0; fsec_r <= '0; pay_cnt <= '0; pkt_cnt <= '0; sent_cnt <= '0;
      busy_r <= 1'b0; done_r <= 1'b0; cfg_err_r <= 1'b0;
    end else begin
      if (state == IDLE && !ctrl[0])
        done_r <= 1'b0;
      if (start_req) begin
        if (cfg_bad) begin
          cfg_err_r <= 1'b1;
        end else begin
          sid_r       <= streamID;
          psize_r     <= pkt_size;
          remaining_r <= words_to_pack;
          cont_r      <= (words_to_pack == '0);
          pay_cnt     <= '0;
          cfg_err_r   <= 1'b0;
          busy_r      <= 1'b1;
          done_r      <= 1'b0;
        end
      end
      if (next_state == HDR && state != HDR) begin
        sec_r  <= timestamp_sec;
        fsec_r <= timestamp_fsec;
      end
      if (state == PAYLOAD && hs)
        pay_cnt <= pay_last ? '0 : pay_cnt + PKT_SIZE_W'(1);
      if (pkt_end) begin
        pkt_cnt  <= pkt_cnt + 4'd1;
        sent_cnt <= sent_cnt + 16'd1;
        if (!cont_r)
          remaining_r <= rem_after;
        if (next_state == IDLE) begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vita49_pack_v2.sv
// Directed bench for vita49_pack_v2: one instance with timestamp and trailer,
// one without, both fed by counting sources and observed by handshake monitors.
module tb_vita49_pack_v2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sid, ts_sec;
  logic [63:0] ts_fsec;
  logic [15:0] psize;
  logic [31:0] wtp;

  logic [31:0] s_tdata_a, m_tdata_a, status_a, ctrl_a;
  logic        s_tvalid_a, s_tready_a, m_tvalid_a, m_tlast_a, m_tready_a;
  logic [31:0] s_tdata_b, m_tdata_b, status_b, ctrl_b;
  logic        s_tvalid_b, s_tready_b, m_tvalid_b, m_tlast_b, m_tready_b;

  logic [32:0] qa[$];
  logic [32:0] qb[$];
  logic        rand_ready, stab_chk, stalled_prev;
  logic [32:0] hold_word;
  int          stall_viol, stall_seen;
  int          tests_run, fails;
  int          qbase;
  logic [31:0] pay_base;

  vita49_pack_v2 #(.PKT_SIZE_W(16), .WTP_W(32), .TS_EN(1), .TRAILER_EN(1)) dut_a (
    .AXIS_ACLK(clk), .AXIS_ARESET(rst),
    .S_AXIS_TDATA(s_tdata_a), .S_AXIS_TVALID(s_tvalid_a), .S_AXIS_TREADY(s_tready_a),
    .M_AXIS_TDATA(m_tdata_a), .M_AXIS_TVALID(m_tvalid_a), .M_AXIS_TLAST(m_tlast_a),
    .M_AXIS_TREADY(m_tready_a), .ctrl(ctrl_a), .status(status_a), .streamID(sid),
    .pkt_size(psize), .words_to_pack(wtp), .timestamp_sec(ts_sec), .timestamp_fsec(ts_fsec));

  vita49_pack_v2 #(.PKT_SIZE_W(16), .WTP_W(32), .TS_EN(0), .TRAILER_EN(0)) dut_b (
    .AXIS_ACLK(clk), .AXIS_ARESET(rst),
    .S_AXIS_TDATA(s_tdata_b), .S_AXIS_TVALID(s_tvalid_b), .S_AXIS_TREADY(s_tready_b),
    .M_AXIS_TDATA(m_tdata_b), .M_AXIS_TVALID(m_tvalid_b), .M_AXIS_TLAST(m_tlast_b),
    .M_AXIS_TREADY(m_tready_b), .ctrl(ctrl_b), .status(status_b), .streamID(sid),
    .pkt_size(psize), .words_to_pack(wtp), .timestamp_sec(ts_sec), .timestamp_fsec(ts_fsec));

  always #5 clk = ~clk;

  // Counting sources, sink ready generation and handshake monitors
  initial begin
    logic fire_a, fire_b;
    s_tvalid_a = 1'b1; s_tdata_a = 32'hA000_0000; m_tready_a = 1'b1;
    s_tvalid_b = 1'b1; s_tdata_b = 32'hB000_0000; m_tready_b = 1'b1;
    stalled_prev = 1'b0; hold_word = '0; stall_viol = 0; stall_seen = 0;
    forever begin
      @(negedge clk);
      fire_a = s_tvalid_a && s_tready_a;
      fire_b = s_tvalid_b && s_tready_b;
      if (m_tvalid_a && m_tready_a) qa.push_back({m_tlast_a, m_tdata_a});
      if (m_tvalid_b && m_tready_b) qb.push_back({m_tlast_b, m_tdata_b});
      if (stab_chk && stalled_prev && ({m_tlast_a, m_tdata_a} !== hold_word)) stall_viol++;
      stalled_prev = m_tvalid_a && !m_tready_a;
      hold_word = {m_tlast_a, m_tdata_a};
      if (stab_chk && stalled_prev) stall_seen++;
      @(posedge clk);
      #1;
      if (fire_a) s_tdata_a = s_tdata_a + 32'd1;
      if (fire_b) s_tdata_b = s_tdata_b + 32'd1;
      m_tready_a = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [31:0] c, input logic [31:0] id,
                               input logic [15:0] ps, input logic [31:0] w);
    tick(1);
    sid = id; psize = ps; wtp = w;
    qbase = qa.size();
    pay_base = s_tdata_a;
    ctrl_a = c;
  endtask

  task automatic resetPulse();
    tick(1);
    rst = 1'b1; ctrl_a = '0; ctrl_b = '0; rand_ready = 1'b0; stab_chk = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic waitDoneA(input string tag, input int budget);
    int n = 0;
    while (status_a[1] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_done"}, 64'(status_a[1]), 64'd1);
  endtask

  task automatic checkPacketA(input string tag, input int p, input logic [31:0] hdr,
                              input int plen, input logic [31:0] trl, input logic [31:0] pay0);
    int bad = 0;
    checkOutput({tag, "_hdr"}, qa[p], {1'b0, hdr});
    checkOutput({tag, "_sid"}, qa[p+1], {1'b0, sid});
    checkOutput({tag, "_tsi"}, qa[p+2], {1'b0, ts_sec});
    checkOutput({tag, "_tsf_hi"}, qa[p+3], {1'b0, ts_fsec[63:32]});
    checkOutput({tag, "_tsf_lo"}, qa[p+4], {1'b0, ts_fsec[31:0]});
    for (int i = 0; i < plen; i++)
      if (qa[p+5+i] !== {1'b0, pay0 + 32'(i)}) bad++;
    checkOutput({tag, "_payload_bad_words"}, 64'(bad), 64'd0);
    checkOutput({tag, "_trailer_tlast"}, qa[p+5+plen], {1'b1, trl});
  endtask

  initial begin
    int n;
    logic [31:0] b_base;
    tests_run = 0; fails = 0;
    rst = 1'b1; ctrl_a = '0; ctrl_b = '0; rand_ready = 1'b0; stab_chk = 1'b0;
    sid = '0; psize = '0; wtp = '0; qbase = 0; pay_base = '0;
    ts_sec = 32'h5EC0_0001; ts_fsec = 64'h0123_4567_89AB_CDEF;
    tick(3);
    checkOutput("reset_status", status_a, 0);
    checkOutput("reset_m_tvalid", m_tvalid_a, 0);
    checkOutput("reset_m_tlast", m_tlast_a, 0);
    checkOutput("reset_s_tready", s_tready_a, 0);
    checkOutput("reset_m_tdata", m_tdata_a, 0);
    rst = 1'b0;

    // Two full packets with timestamp and trailer
    applyStimulus(32'h1, 32'hDEADBEEF, 16'h20, 32'h40);
    waitDoneA("t1", 400);
    checkOutput("t1_words", qa.size() - qbase, 76);
    checkPacketA("t1_p0", qbase, 32'h14500026, 32, 32'h0, pay_base);
    checkPacketA("t1_p1", qbase + 38, 32'h14510026, 32, 32'h1, pay_base + 32);
    checkOutput("t1_status", status_a, 32'h0002_0022);
    tick(1);
    ctrl_a = '0;
    tick(1);
    checkOutput("t1_done_clears", status_a, 32'h0002_0020);

    // Short final packet
    resetPulse();
    applyStimulus(32'h1, 32'hDEADBEEF, 16'h20, 32'h45);
    waitDoneA("t2", 400);
    checkOutput("t2_words", qa.size() - qbase, 87);
    checkPacketA("t2_p1", qbase + 38, 32'h14510026, 32, 32'h0, pay_base + 32);
    checkPacketA("t2_p2", qbase + 76, 32'h1452000B, 5, 32'h1, pay_base + 64);

    // Random sink backpressure
    resetPulse();
    rand_ready = 1'b1; stab_chk = 1'b1;
    applyStimulus(32'h1, 32'h0000CAFE, 16'd8, 32'd24);
    waitDoneA("t3", 2000);
    checkOutput("t3_words", qa.size() - qbase, 42);
    checkPacketA("t3_p0", qbase, 32'h1450000E, 8, 32'h0, pay_base);
    checkPacketA("t3_p1", qbase + 14, 32'h1451000E, 8, 32'h0, pay_base + 8);
    checkPacketA("t3_p2", qbase + 28, 32'h1452000E, 8, 32'h1, pay_base + 16);
    checkOutput("t3_stall_stable", 64'(stall_viol), 64'd0);
    checkOutput("t3_stalls_seen", 64'(stall_seen > 0), 64'd1);
    rand_ready = 1'b0; stab_chk = 1'b0;

    // Packet count wraps after 16 packets
    resetPulse();
    applyStimulus(32'h1, 32'h00000017, 16'd4, 32'd68);
    waitDoneA("t4", 1000);
    checkOutput("t4_words", qa.size() - qbase, 170);
    checkOutput("t4_hdr16", qa[qbase + 150], {1'b0, 32'h145F000A});
    checkPacketA("t4_p17", qbase + 160, 32'h1450000A, 4, 32'h1, pay_base + 64);
    checkOutput("t4_status", status_a, 32'h0011_0012);

    // Hard reset in the middle of a continuous run
    resetPulse();
    applyStimulus(32'h1, 32'h00000099, 16'h20, 32'h0);
    tick(8);
    checkOutput("t5_busy_pre", status_a[0], 1);
    checkOutput("t5_in_payload", s_tready_a, 1);
    #1 rst = 1'b1;
    #1;
    checkOutput("t5_rst_m_tvalid", m_tvalid_a, 0);
    checkOutput("t5_rst_s_tready", s_tready_a, 0);
    checkOutput("t5_rst_m_tlast", m_tlast_a, 0);
    checkOutput("t5_rst_status", status_a, 0);
    ctrl_a = '0;
    tick(2);
    rst = 1'b0;

    // Zero packet size is rejected
    applyStimulus(32'h1, 32'h00000099, 16'd0, 32'h10);
    tick(2);
    checkOutput("t6_cfg_err", status_a[2:0], 3'b100);

    // Passthrough
    applyStimulus(32'h4, 32'h00000099, 16'd0, 32'h10);
    #1;
    checkOutput("t7_pass_tdata", m_tdata_a, s_tdata_a);
    checkOutput("t7_pass_tvalid", m_tvalid_a, 1);
    checkOutput("t7_pass_tlast", m_tlast_a, 0);
    tick(5);
    checkOutput("t7_pass_count", qa.size() - qbase, 5);
    checkOutput("t7_pass_word4", qa[qbase + 4], {1'b0, pay_base + 32'd4});
    ctrl_a = '0;

    // Valid start clears cfg_err; dropping run completes the current packet
    applyStimulus(32'h1, 32'h00000099, 16'd4, 32'h0);
    tick(1);
    checkOutput("t8_cfg_err_clear", status_a[2:0], 3'b001);
    tick(12);
    ctrl_a = '0;
    waitDoneA("t8", 200);
    n = qa.size() - qbase;
    checkOutput("t8_whole_packets", 64'(n % 10), 64'd0);
    checkOutput("t8_last_trailer", qa[qa.size() - 1], {1'b1, 32'h0});
    checkOutput("t8_not_busy", status_a[0], 0);

    // No timestamp, no trailer variant
    resetPulse();
    sid = 32'h12345678; psize = 16'h20; wtp = 32'h20;
    b_base = s_tdata_b;
    ctrl_b = 32'h1;
    n = 0;
    while (status_b[1] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("b_done", status_b[1], 1);
    checkOutput("b_words", qb.size(), 34);
    checkOutput("b_hdr", qb[0], {1'b0, 32'h10000022});
    checkOutput("b_sid", qb[1], {1'b0, 32'h12345678});
    checkOutput("b_first_payload", qb[2], {1'b0, b_base});
    checkOutput("b_word33", qb[32], {1'b0, b_base + 32'd30});
    checkOutput("b_word34_tlast", qb[33], {1'b1, b_base + 32'd31});
    checkOutput("b_status", status_b, 32'h0001_0012);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
